mem_rd_req_gen: RTL and testbench

- Memory-read request generator directly upstream of the buffer read counter.
- Accepts one stream-read command (base address, total words, PU id, data type) from the layer controller and splits it into AXI-style read bursts.
- For every burst accepted by the memory interface, pulses rd_req with that burst's word count, PU id and d_type. The downstream counter uses these fields to know how many buffer pops to expect.
- Limits in-flight bursts using a credit counter that is returned by rd_burst_done.

---
 rtl/mem_rd_req_gen_pkg.sv | 13 +
 rtl/mem_rd_burst_calc.sv | 32 +++
 rtl/mem_rd_req_gen.sv | 102 ++++++++++
 tb/tb_mem_rd_req_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rd_req_gen_pkg.sv
// mem_rd_req_gen_pkg: shared encodings, FSM states and constants for the read request generator
`ifndef C_LOG_2
`define C_LOG_2(n) ($clog2(n))
`endif
package mem_rd_req_gen_pkg;
  localparam logic [1:0] D_TYPE_WEIGHT = 2'd0;
  localparam logic [1:0] D_TYPE_BUF    = 2'd1;
  localparam int BOUNDARY_4K = 4096;
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;
  function automatic int pu_id_w(input int num_pu);
    return `C_LOG_2(num_pu) + 1;
  endfunction
endpackage

// File: rtl/mem_rd_burst_calc.sv
// mem_rd_burst_calc: beats of the next burst from address and remaining words (optional MEM_RD_4K_BOUNDARY_EN)
module mem_rd_burst_calc
  import mem_rd_req_gen_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int RD_SIZE_W = 20,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 16
) (
  input  logic [ADDR_W-1:0]    addr,
  input  logic [RD_SIZE_W-1:0] remaining,
  output logic [8:0]           beats,
  output logic [7:0]           rd_len
);
  logic [8:0] b_rem;
  logic unused_addr;
  always_comb begin
    b_rem = (remaining < RD_SIZE_W'(MAX_BURST)) ? 9'(remaining) : 9'(MAX_BURST);
    rd_len = 8'(beats - 9'd1);
    unused_addr = ^addr;
  end
`ifdef MEM_RD_4K_BOUNDARY_EN
  localparam int WB_SH = $clog2(DATA_W / 8);
  logic [12:0] w4k;
  always_comb begin
    w4k = (13'(BOUNDARY_4K) - {1'b0, addr[11:0]}) >> WB_SH;
    beats = ({4'd0, b_rem} > w4k) ? 9'(w4k) : b_rem;
  end
`else
  always_comb beats = b_rem;
`endif
endmodule

// File: rtl/mem_rd_req_gen.sv
// mem_rd_req_gen: splits a stream-read command into credit-limited bursts and pulses rd_req per accepted burst
module mem_rd_req_gen
  import mem_rd_req_gen_pkg::*;
#(
  parameter int NUM_PU          = 1,
  parameter int D_TYPE_W        = 2,
  parameter int RD_SIZE_W       = 20,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 64,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int PU_ID_W         = `C_LOG_2(NUM_PU) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [RD_SIZE_W-1:0] cmd_size,
  input  logic [PU_ID_W-1:0]   cmd_pu_id,
  input  logic [D_TYPE_W-1:0]  cmd_d_type,
  output logic                 rd_addr_valid,
  input  logic                 rd_addr_ready,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic [7:0]           rd_len,
  input  logic                 rd_burst_done,
  output logic                 rd_req,
  output logic [RD_SIZE_W-1:0] rd_req_size,
  output logic [PU_ID_W-1:0]   rd_req_pu_id,
  output logic [D_TYPE_W-1:0]  rd_req_d_type,
  output logic                 busy
);
  localparam int WB_SH = $clog2(DATA_W / 8);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  state_t state, state_nx;
  logic rst_done;
  logic [ADDR_W-1:0] addr;
  logic [RD_SIZE_W-1:0] remaining;
  logic [PU_ID_W-1:0] pu_id;
  logic [D_TYPE_W-1:0] d_type;
  logic [OUT_W-1:0] outstanding;
  logic [8:0] beats;
  logic [7:0] len;
  logic take, acc, last, credit;
  mem_rd_burst_calc #(
    .ADDR_W(ADDR_W), .RD_SIZE_W(RD_SIZE_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
  ) u_calc (
    .addr(addr), .remaining(remaining), .beats(beats), .rd_len(len)
  );
  always_comb begin
    take = cmd_valid && cmd_ready;
    acc = rd_addr_valid && rd_addr_ready;
    last = remaining == RD_SIZE_W'(beats);
    credit = outstanding < OUT_W'(MAX_OUTSTANDING);
  end
  always_ff @(posedge clk)
    state <= !reset ? IDLE : state_nx;
  always_comb
    state_nx = (state == IDLE) ? ((take && cmd_size != '0) ? ISSUE : IDLE)
                               : ((acc && last) ? IDLE : ISSUE);
  // cmd_ready is held low through reset and for the edge that releases it
  always_comb begin
    cmd_ready = rst_done && state == IDLE;
    rd_addr_valid = state == ISSUE && credit;
    rd_addr = rd_addr_valid ? addr : '0;
    rd_len = rd_addr_valid ? len : '0;
    busy = state != IDLE || outstanding != '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      rst_done <= 1'b0;
      addr <= '0;
      remaining <= '0;
      pu_id <= '0;
      d_type <= '0;
      outstanding <= '0;
      rd_req <= 1'b0;
      rd_req_size <= '0;
      rd_req_pu_id <= '0;
      rd_req_d_type <= '0;
    end else begin
      rst_done <= 1'b1;
      rd_req <= acc;
      // a done with nothing outstanding is dropped so the counter cannot underflow
      outstanding <= outstanding + OUT_W'(acc) - OUT_W'(rd_burst_done && outstanding != '0);
      if (take) begin
        addr <= cmd_addr;
        remaining <= cmd_size;
        pu_id <= cmd_pu_id;
        d_type <= cmd_d_type;
      end else if (acc) begin
        addr <= addr + (ADDR_W'(beats) << WB_SH);
        remaining <= remaining - RD_SIZE_W'(beats);
      end
      if (acc) begin
        rd_req_size <= RD_SIZE_W'(beats);
        rd_req_pu_id <= pu_id;
        rd_req_d_type <= d_type;
      end
    end
  end
endmodule

// File: tb/tb_mem_rd_req_gen.sv
// tb_mem_rd_req_gen: randomized self-checking bench against a burst-list reference model
module tb_mem_rd_req_gen;
  typedef struct {
    int unsigned addr;
    int beats;
    int pu;
    int dt;
  } burst_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [19:0] cmd_size = '0;
  logic [0:0] cmd_pu_id = '0;
  logic [1:0] cmd_d_type = '0;
  logic rd_addr_valid;
  logic rd_addr_ready = 1'b0;
  logic [31:0] rd_addr;
  logic [7:0] rd_len;
  logic rd_burst_done = 1'b0;
  logic rd_req;
  logic [19:0] rd_req_size;
  logic [0:0] rd_req_pu_id;
  logic [1:0] rd_req_d_type;
  logic busy;
  int vectors = 0;
  int errors = 0;
  burst_t exp_q[$];
  burst_t last_b;
  int out_m = 0;
  bit acc_last = 0;
  bit rst_edge = 1;
  int n_acc = 0;
  int n_req = 0;
  int sum_req = 0;
  bit done_en = 1, stray = 0, man_done = 0;
  bit ready_rnd = 0, ready_fix = 1;

  mem_rd_req_gen dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_pu_id(cmd_pu_id), .cmd_d_type(cmd_d_type),
    .rd_addr_valid(rd_addr_valid), .rd_addr_ready(rd_addr_ready), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_burst_done(rd_burst_done), .rd_req(rd_req), .rd_req_size(rd_req_size),
    .rd_req_pu_id(rd_req_pu_id), .rd_req_d_type(rd_req_d_type), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // expected bursts for one command, straight from the splitting rules
  function automatic void plan(input int unsigned a, input int n, input int pu, input int dt);
    while (n > 0) begin
      int b;
      b = n < 16 ? n : 16;
`ifdef MEM_RD_4K_BOUNDARY_EN
      if ((4096 - (a % 4096)) / 8 < b) b = (4096 - (a % 4096)) / 8;
`endif
      exp_q.push_back('{a, b, pu, dt});
      a += b * 8;
      n -= b;
    end
  endfunction

  always @(negedge clk) begin
    bit acc;
    if (rst_edge) begin
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_valid", rd_addr_valid, 0);
      check("rst_rd_req", rd_req, 0);
      check("rst_busy", busy, 0);
      check("rst_addr", rd_addr, 0);
      check("rst_len", rd_len, 0);
      check("rst_req_size", rd_req_size, 0);
      check("rst_req_pu", rd_req_pu_id, 0);
      exp_q.delete();
      out_m = 0;
      acc_last = 0;
    end else begin
      check("cmd_ready", cmd_ready, exp_q.size() == 0);
      check("rd_addr_valid", rd_addr_valid, exp_q.size() != 0 && out_m < 4);
      check("busy", busy, exp_q.size() != 0 || out_m != 0);
      check("rd_req", rd_req, acc_last);
      if (rd_addr_valid && exp_q.size() != 0) begin
        check("rd_addr", rd_addr, exp_q[0].addr);
        check("rd_len", rd_len, exp_q[0].beats - 1);
      end
      if (rd_req) begin
        n_req++;
        sum_req += int'(rd_req_size);
        if (acc_last) begin
          check("req_size", rd_req_size, last_b.beats);
          check("req_pu", rd_req_pu_id, last_b.pu);
          check("req_dtype", rd_req_d_type, last_b.dt);
        end
      end
    end
    rst_edge = !reset;
    if (reset) begin
      acc = rd_addr_valid && rd_addr_ready;
      acc_last = acc;
      if (acc) n_acc++;
      if (acc && exp_q.size() != 0) last_b = exp_q.pop_front();
      if (rd_burst_done && out_m > 0) out_m--;
      if (acc) out_m++;
      if (cmd_valid && cmd_ready) plan(cmd_addr, int'(cmd_size), int'(cmd_pu_id), int'(cmd_d_type));
    end else acc_last = 0;
  end

  always @(posedge clk) begin
    #2;
    rd_addr_ready = ready_rnd ? ($urandom_range(0, 3) == 0) : ready_fix;
    rd_burst_done = done_en ? ((out_m > 0 || stray) && $urandom_range(0, 1) == 1) : man_done;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int unsigned a, input int n, input int pu, input int dt);
    bit ok = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1;
    cmd_addr = a;
    cmd_size = 20'(n);
    cmd_pu_id = 1'(pu);
    cmd_d_type = 2'(dt);
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
    end
    if (!ok) check("cmd_timeout", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 0;
  endtask

  task automatic wait_idle(input bit need_free);
    bit ok = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = exp_q.size() == 0 && (!need_free || out_m == 0);
    end
    if (!ok) check("idle_timeout", 0, 1);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int a0, r0, s0, sz;
    int unsigned ad;
    cycles(3);
    reset = 1;
    cycles(1);
    @(negedge clk);
    check("ready_after_release", cmd_ready, 1);
    r0 = n_req; s0 = sum_req;
    send_cmd(32'h1000, 40, 1, 1);
    wait_idle(1);
    check("basic_req_count", n_req - r0, 3);
    check("basic_req_sum", sum_req - s0, 40);
    r0 = n_req;
    send_cmd(32'h3000, 0, 0, 0);
    cycles(4);
    check("zero_req_count", n_req - r0, 0);
    check("zero_busy", busy, 0);
    done_en = 0;
    a0 = n_acc;
    send_cmd(32'h4000, 128, 0, 2);
    cycles(20);
    check("credit_stop", n_acc - a0, 4);
    check("credit_valid_low", rd_addr_valid, 0);
    man_done = 1;
    cycles(1);
    man_done = 0;
    cycles(3);
    check("credit_resume", n_acc - a0, 5);
    done_en = 1;
    wait_idle(1);
    ready_rnd = 1;
    stray = 1;
    for (int k = 0; k < 5; k++) begin
      sz = k == 0 ? 1000 : int'($urandom_range(1, 300));
      ad = $urandom & 32'hFFFF_FFF8;
      if (k == 4) ad = 32'hFFFF_FFC0;
      s0 = sum_req;
      send_cmd(ad, sz, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      wait_idle(0);
      check("rand_req_sum", sum_req - s0, sz);
    end
    ready_rnd = 0;
    stray = 0;
    wait_idle(1);
    r0 = n_req;
    send_cmd(32'h0FF0, 16, 1, 0);
    wait_idle(1);
`ifdef MEM_RD_4K_BOUNDARY_EN
    check("4k_req_count", n_req - r0, 2);
`else
    check("4k_req_count", n_req - r0, 1);
`endif
    ready_fix = 0;
    a0 = n_acc;
    send_cmd(32'h2000, 40, 0, 1);
    cycles(2);
    ready_fix = 1;
    cycles(1);
    ready_fix = 0;
    cycles(2);
    check("mid_acc_count", n_acc - a0, 1);
    reset = 0;
    cycles(3);
    reset = 1;
    ready_fix = 1;
    cycles(2);
    r0 = n_req; s0 = sum_req;
    send_cmd(32'h5000, 24, 1, 3);
    wait_idle(1);
    check("post_rst_req_count", n_req - r0, 2);
    check("post_rst_req_sum", sum_req - s0, 24);
    check("post_rst_busy", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
